fft_frame_sequencer: RTL and testbench
======================================

Name: fft_frame_sequencer

Overview:
- Frame-level controller wrapped around the radix-2 FFT core.
- Gates an incoming real sample stream into the core's input stream, one frame at a time.
- Issues `run` once the buffer is full and waits for `done`.
- Sweeps the DMA read port over the lower half-spectrum, presents each bin on a valid/ready output stream with the frame's block-floating-point exponent, then pulses `fin` to release the core for the next frame.

Parameters:
- FFT_LENGTH, 1024: frame length, power of 2; must match the core.
- FFT_DW, 16: sample and bin data width.
- FFT_N, $clog2(FFT_LENGTH): derived; never overridden.
- OUT_BINS, FFT_LENGTH/2: bins read out per frame, indices 0..OUT_BINS-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request to capture one frame
- continuous  in  1  level; when 1, frames repeat back-to-back without `start`
- sample_valid  in  1  input sample handshake valid
- sample_ready  out  1  input sample handshake ready
- sample_data  in  FFT_DW  signed real sample
- fft_status  in  3  core status (1 input stream, 2 full buffer, 3 run, 4 done)
- fft_done  in  1  core done flag
- fft_bfpexp  in  8  core BFP exponent, signed
- fft_autorun  out  1  tied 0
- fft_ifft  out  1  tied 0
- fft_run  out  1  core run request
- fft_fin  out  1  core release pulse
- fft_istream_active  out  1  core input write strobe
- fft_ireal  out  FFT_DW  core real input
- fft_iimag  out  FFT_DW  core imaginary input, tied 0
- fft_dmaact  out  1  core DMA read enable
- fft_dmaa  out  FFT_N  core DMA address
- fft_dmadr_real  in  FFT_DW  core DMA read data, real
- fft_dmadr_imag  in  FFT_DW  core DMA read data, imaginary
- bin_valid  out  1  output bin handshake valid
- bin_ready  in  1  output bin handshake ready
- bin_index  out  FFT_N-1  index of the presented bin
- bin_real  out  FFT_DW  bin real part
- bin_imag  out  FFT_DW  bin imaginary part
- bin_last  out  1  marks the bin at index OUT_BINS-1
- frame_exp  out  8  BFP exponent of the frame being read out
- busy  out  1  high in any state except IDLE
- frame_count  out  16  completed-frame counter

Behaviour:

Reset:
- Reset is synchronous, active-high; clock is clk.
- On reset: state IDLE; all outputs 0; sample counter, bin counter, frame_count, frame_exp all cleared.
- Reset mid-frame abandons the frame. The core is reset on the same line by the top level.

States and transitions:
- IDLE → FILL when `start`, or when `continuous`=1.
- FILL:
  - sample_ready = (fft_status==1).
  - fft_istream_active = sample_valid & sample_ready.
  - fft_ireal = sample_data, combinational pass-through.
  - Each accepted sample increments a counter of width FFT_N+1.
  - When the FFT_LENGTH-th sample is accepted → RUN on the next cycle. No further samples are accepted in that cycle.
  - fft_status other than 1 (e.g. core still IDLE after reset) stalls with sample_ready=0; no samples are dropped.
- RUN:
  - fft_run = 1 while fft_status==2.
  - When fft_done=1 → READ, latching frame_exp <= fft_bfpexp in the same cycle.
- READ: two-phase loop per bin k, starting at k=0.
  - ISSUE: fft_dmaact=1, fft_dmaa=k for exactly one cycle.
  - CAPTURE: next cycle, register fft_dmadr_real/imag into bin_real/imag (1-cycle DMA latency). Set bin_valid=1, bin_index=k, bin_last=(k==OUT_BINS-1).
  - HOLD: bin outputs stable while bin_valid & !bin_ready.
  - On handshake: if not last, k++ and go to ISSUE the next cycle; else → FIN.
  - Peak throughput is 1 bin per 2 cycles.
  - fft_dmaact=0 outside ISSUE.
- FIN:
  - fft_fin=1 for exactly one cycle; frame_count++ (wraps at 2^16).
  - Next: FILL if `continuous`=1, else IDLE.

Boundary rules:
- `start` while busy is ignored, not queued.
- `continuous` deasserted mid-frame: the current frame completes, then the block returns to IDLE.
- frame_exp holds its value until the next READ entry.
- bin_ready held low indefinitely stalls the block in HOLD; the core remains in DONE.
- sample_valid during RUN, READ or FIN sees sample_ready=0.

Test Plan:
- FFT_LENGTH=16, start pulse, 16 samples of value 1000 with valid every cycle → 16 istream_active strobes, then fft_run until status 3. After done: 8 bins, indices 0..7, DC bin real equal to the core's scaled sum, bin_last on index 7 only, then one fft_fin pulse; frame_count=1; return to IDLE.
- sample_valid toggling 1/0 with status 1 → exactly 16 accepted samples; the 17th valid is not accepted (sample_ready=0 after the 16th).
- bin_ready low for 5 cycles on bin 3 → bin_index/real/imag stable all 5 cycles; dmaact does not reissue; bin 4 address issued the cycle after the handshake.
- continuous=1 for 3 frames → frame_count=3; FILL re-entered the cycle after each fin; frame_exp updated per frame to the core's bfpexp value (e.g. -2 then 0).
- Reset asserted during READ at bin 5 → next cycle all outputs 0, state IDLE, frame_count unchanged at its pre-reset value of 0.
- start asserted during RUN → no effect; exactly one frame is read out.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller around the radix-2 FFT core: gathers one frame of real
// samples, runs the core, then streams the lower half-spectrum out with its BFP exponent.
module fft_frame_sequencer #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int FFT_N      = $clog2(FFT_LENGTH),
    parameter int OUT_BINS   = FFT_LENGTH / 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    input  logic signed [FFT_DW-1:0] sample_data,
    input  logic        [2:0]        fft_status,
    input  logic                     fft_done,
    input  logic signed [7:0]        fft_bfpexp,
    output logic                     fft_autorun,
    output logic                     fft_ifft,
    output logic                     fft_run,
    output logic                     fft_fin,
    output logic                     fft_istream_active,
    output logic signed [FFT_DW-1:0] fft_ireal,
    output logic signed [FFT_DW-1:0] fft_iimag,
    output logic                     fft_dmaact,
    output logic        [FFT_N-1:0]  fft_dmaa,
    input  logic signed [FFT_DW-1:0] fft_dmadr_real,
    input  logic signed [FFT_DW-1:0] fft_dmadr_imag,
    output logic                     bin_valid,
    input  logic                     bin_ready,
    output logic        [FFT_N-2:0]  bin_index,
    output logic signed [FFT_DW-1:0] bin_real,
    output logic signed [FFT_DW-1:0] bin_imag,
    output logic                     bin_last,
    output logic signed [7:0]        frame_exp,
    output logic                     busy,
    output logic        [15:0]       frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_ISSUE,
        S_CAPTURE,
        S_HOLD,
        S_FIN
    } state_t;

    localparam logic [2:0]       CORE_ISTREAM = 3'd1;
    localparam logic [2:0]       CORE_FULL    = 3'd2;
    localparam logic [FFT_N:0]   LAST_SAMPLE  = (FFT_N + 1)'(FFT_LENGTH - 1);
    localparam logic [FFT_N-2:0] LAST_BIN     = (FFT_N - 1)'(OUT_BINS - 1);

    state_t state;
    state_t state_nxt;

    logic [FFT_N:0]            sample_cnt;
    logic [FFT_N-2:0]          bin_k;
    logic signed [FFT_DW-1:0]  bin_real_p1;
    logic signed [FFT_DW-1:0]  bin_imag_p1;
    logic                      is_last_bin;
    logic                      bin_fire;

    assign is_last_bin = (bin_k == LAST_BIN);
    assign bin_fire    = bin_valid & bin_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        sample_ready       = 1'b0;
        fft_istream_active = 1'b0;
        fft_ireal          = '0;
        fft_iimag          = '0;
        fft_autorun        = 1'b0;
        fft_ifft           = 1'b0;
        fft_run            = 1'b0;
        fft_fin            = 1'b0;
        fft_dmaact         = 1'b0;
        fft_dmaa           = '0;
        bin_valid          = 1'b0;
        bin_index          = bin_k;
        bin_real           = bin_real_p1;
        bin_imag           = bin_imag_p1;
        bin_last           = 1'b0;
        busy               = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start || continuous) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                sample_ready       = (fft_status == CORE_ISTREAM);
                fft_istream_active = sample_valid & sample_ready;
                fft_ireal          = sample_data;
                if (fft_istream_active && sample_cnt == LAST_SAMPLE) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                fft_run = (fft_status == CORE_FULL);
                if (fft_done) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fft_dmaact = 1'b1;
                fft_dmaa   = {1'b0, bin_k};
                state_nxt  = S_CAPTURE;
            end
            S_CAPTURE, S_HOLD: begin
                bin_valid = 1'b1;
                bin_last  = is_last_bin;
                // DMA data is only valid in the cycle after the address; the
                // first presentation passes it straight through, later cycles replay the copy.
                if (state == S_CAPTURE) begin
                    bin_real = fft_dmadr_real;
                    bin_imag = fft_dmadr_imag;
                end
                if (bin_ready) begin
                    state_nxt = is_last_bin ? S_FIN : S_ISSUE;
                end else begin
                    state_nxt = S_HOLD;
                end
            end
            S_FIN: begin
                fft_fin   = 1'b1;
                state_nxt = continuous ? S_FILL : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt  <= '0;
            bin_k       <= '0;
            bin_real_p1 <= '0;
            bin_imag_p1 <= '0;
            frame_exp   <= '0;
            frame_count <= '0;
        end else begin
            if (state != S_FILL) begin
                sample_cnt <= '0;
            end else if (fft_istream_active) begin
                sample_cnt <= sample_cnt + (FFT_N + 1)'(1);
            end

            if (state == S_RUN) begin
                bin_k <= '0;
            end else if (bin_fire && !is_last_bin) begin
                bin_k <= bin_k + (FFT_N - 1)'(1);
            end

            // Capture stage: DMA read data becomes the held bin
            if (state == S_CAPTURE) begin
                bin_real_p1 <= fft_dmadr_real;
                bin_imag_p1 <= fft_dmadr_imag;
            end

            if (state == S_RUN && fft_done) begin
                frame_exp <= fft_bfpexp;
            end

            if (state == S_FIN) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer with a behavioural FFT-core stand-in (status, done,
// BFP exponent, one-cycle DMA read) and per-scenario expectations from the stimulus.
module tb_fft_frame_sequencer;

    localparam int L  = 16;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int OB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, start, continuous, sample_valid, bin_ready;
    logic signed [DW-1:0] sample_data;
    logic [2:0]           fft_status;
    logic                 fft_done;
    logic signed [7:0]    fft_bfpexp;
    logic signed [DW-1:0] fft_dmadr_real, fft_dmadr_imag;
    logic                 sample_ready, fft_autorun, fft_ifft, fft_run, fft_fin;
    logic                 fft_istream_active, fft_dmaact, bin_valid, bin_last, busy;
    logic signed [DW-1:0] fft_ireal, fft_iimag, bin_real, bin_imag;
    logic [N-1:0]         fft_dmaa;
    logic [N-2:0]         bin_index;
    logic signed [7:0]    frame_exp;
    logic [15:0]          frame_count;

    int compared = 0;
    int mismatched = 0;

    fft_frame_sequencer #(.FFT_LENGTH(L), .FFT_DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
        .fft_status(fft_status), .fft_done(fft_done), .fft_bfpexp(fft_bfpexp),
        .fft_autorun(fft_autorun), .fft_ifft(fft_ifft), .fft_run(fft_run), .fft_fin(fft_fin),
        .fft_istream_active(fft_istream_active), .fft_ireal(fft_ireal), .fft_iimag(fft_iimag),
        .fft_dmaact(fft_dmaact), .fft_dmaa(fft_dmaa),
        .fft_dmadr_real(fft_dmadr_real), .fft_dmadr_imag(fft_dmadr_imag),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_index(bin_index),
        .bin_real(bin_real), .bin_imag(bin_imag), .bin_last(bin_last),
        .frame_exp(frame_exp), .busy(busy), .frame_count(frame_count)
    );

    logic [104:0] all_out;
    assign all_out = {busy, sample_ready, fft_run, fft_fin, fft_istream_active, fft_dmaact,
                      bin_valid, bin_last, fft_autorun, fft_ifft, fft_ireal, fft_iimag,
                      fft_dmaa, bin_index, bin_real, bin_imag, frame_count, frame_exp};

    // Core stand-in: 0 idle, 1 input stream, 2 full, 3 run, 4 done
    logic [2:0]           core_st;
    int                   core_cnt;
    int                   core_wr;
    logic signed [DW-1:0] core_mem [L];
    logic signed [DW-1:0] tb_re [L];
    logic signed [DW-1:0] tb_im [L];
    logic signed [7:0]    next_exp;

    assign fft_status = core_st;

    function automatic logic signed [DW-1:0] dc_of();
        int s = 0;
        for (int i = 0; i < L; i++) s += int'(core_mem[i]);
        return DW'(s >>> 4);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            core_st        <= 3'd0;
            core_cnt       <= 3;
            core_wr        <= 0;
            fft_done       <= 1'b0;
            fft_bfpexp     <= '0;
            fft_dmadr_real <= '0;
            fft_dmadr_imag <= '0;
        end else begin
            case (core_st)
                3'd0: if (core_cnt == 0) core_st <= 3'd1; else core_cnt <= core_cnt - 1;
                3'd1: if (fft_istream_active) begin
                    core_mem[core_wr] <= fft_ireal;
                    if (core_wr == L - 1) begin
                        core_st <= 3'd2;
                        core_wr <= 0;
                    end else begin
                        core_wr <= core_wr + 1;
                    end
                end
                3'd2: if (fft_run) begin
                    core_st  <= 3'd3;
                    core_cnt <= 4;
                end
                3'd3: if (core_cnt == 0) begin
                    core_st    <= 3'd4;
                    fft_done   <= 1'b1;
                    fft_bfpexp <= next_exp;
                    for (int i = 0; i < L; i++) begin
                        tb_re[i] <= (i == 0) ? dc_of() : DW'($urandom);
                        tb_im[i] <= (i == 0) ? '0 : DW'($urandom);
                    end
                end else begin
                    core_cnt <= core_cnt - 1;
                end
                3'd4: begin
                    // read data is only valid the cycle after the address
                    if (fft_dmaact) begin
                        fft_dmadr_real <= tb_re[fft_dmaa];
                        fft_dmadr_imag <= tb_im[fft_dmaa];
                    end else begin
                        fft_dmadr_real <= DW'($urandom);
                        fft_dmadr_imag <= DW'($urandom);
                    end
                    if (fft_fin) begin
                        core_st  <= 3'd1;
                        fft_done <= 1'b0;
                    end
                end
                default: core_st <= 3'd0;
            endcase
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; sample_valid = 1'b0; bin_ready = 1'b0; continuous = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
    endtask

    // Offers samples until a full frame is taken, then offers one more.
    task automatic feed(input bit toggle, input bit rand_data, input logic signed [DW-1:0] value,
                        output int accepted, output int sum);
        int cyc = 0;
        logic [31:0] r;
        accepted = 0;
        sum = 0;
        while (accepted < L && cyc < 300) begin
            @(negedge clk);
            sample_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            r = $urandom;
            sample_data = rand_data ? r[DW-1:0] : value;
            #1;
            compared++;
            if (fft_istream_active !== (sample_valid & sample_ready) ||
                (sample_ready === 1'b1 && fft_status !== 3'd1)) begin
                mismatched++;
                $display("FAIL fill_handshake cyc %0d: active=%b valid=%b ready=%b status=%0d",
                         cyc, fft_istream_active, sample_valid, sample_ready, fft_status);
            end
            if (fft_istream_active === 1'b1) begin
                compared++;
                if (fft_ireal !== sample_data) begin
                    mismatched++;
                    $display("FAIL ireal_passthru: got %0d want %0d", fft_ireal, sample_data);
                end
                accepted++;
                sum += int'(sample_data);
            end
            cyc++;
        end
        compared++;
        if (accepted != L) begin
            mismatched++;
            $display("FAIL fill_count: got %0d want %0d", accepted, L);
        end
        @(negedge clk); sample_valid = 1'b1; #1;
        compared++;
        if (sample_ready !== 1'b0 || fft_istream_active !== 1'b0 || fft_run !== 1'b1) begin
            mismatched++;
            $display("FAIL after_fill: ready=%b active=%b run=%b want 0 0 1",
                     sample_ready, fft_istream_active, fft_run);
        end
        @(negedge clk); sample_valid = 1'b0; #1;
        compared++;
        if (fft_run !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL run_release: run=%b busy=%b want 0 1", fft_run, busy);
        end
    endtask

    // Walks the readout: issue / capture / optional hold per bin, then the fin pulse.
    task automatic read_frame(input int stall_bin, input int stall_len, input int abort_bin,
                              output logic signed [DW-1:0] dc_real);
        int t = 0;
        dc_real = '0;
        while (fft_dmaact !== 1'b1 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        compared++;
        if (t >= 200) begin
            mismatched++;
            $display("FAIL read_start: no dmaact within %0d cycles", t);
            return;
        end
        compared++;
        if (frame_exp !== next_exp) begin
            mismatched++;
            $display("FAIL frame_exp: got %0d want %0d", frame_exp, next_exp);
        end
        for (int k = 0; k < OB; k++) begin
            compared++;
            if (fft_dmaact !== 1'b1 || fft_dmaa !== 4'(k) || bin_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL issue bin %0d: dmaact=%b addr=%0d valid=%b", k, fft_dmaact, fft_dmaa, bin_valid);
            end
            for (int s = 0; s <= ((k == stall_bin) ? stall_len : 0); s++) begin
                @(negedge clk);
                bin_ready = ((k == stall_bin && s < stall_len) || k == abort_bin) ? 1'b0 : 1'b1;
                #1;
                compared++;
                if (bin_valid !== 1'b1 || bin_index !== 3'(k) || bin_real !== tb_re[k] ||
                    bin_imag !== tb_im[k] || bin_last !== (k == OB - 1) || fft_dmaact !== 1'b0) begin
                    mismatched++;
                    $display("FAIL bin %0d cyc %0d: v=%b idx=%0d re=%0d im=%0d last=%b dmaact=%b want re=%0d im=%0d",
                             k, s, bin_valid, bin_index, bin_real, bin_imag, bin_last, fft_dmaact, tb_re[k], tb_im[k]);
                end
                if (k == 0) dc_real = bin_real;
                if (k == abort_bin) return;
            end
            @(negedge clk); bin_ready = 1'b0; #1;
        end
        compared++;
        if (fft_fin !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL fin_pulse: fin=%b busy=%b want 1 1", fft_fin, busy);
        end
        @(negedge clk); #1;
        compared++;
        if (fft_fin !== 1'b0) begin
            mismatched++;
            $display("FAIL fin_width: fin=%b want 0", fft_fin);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; continuous = 1'b1; sample_valid = 1'b1; bin_ready = 1'b1;
        sample_data = 16'sd1234;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        start = 1'b0; continuous = 1'b0; sample_valid = 1'b0; bin_ready = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        compared++;
        if (busy !== 1'b0 || frame_count !== 16'd0) begin
            mismatched++;
            $display("FAIL post_reset_idle: busy=%b count=%0d", busy, frame_count);
        end
    endtask

    task automatic test_single_frame();
        int acc, sum;
        logic signed [DW-1:0] dc;
        do_reset();
        next_exp = -8'sd3;
        pulse_start();
        feed(1'b0, 1'b0, 16'sd1000, acc, sum);
        read_frame(-1, 0, -1, dc);
        compared++;
        if (dc !== 16'sd1000) begin
            mismatched++;
            $display("FAIL dc_bin: got %0d want 1000", dc);
        end
        compared++;
        if (frame_count !== 16'd1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_done: count=%0d busy=%b want 1 0", frame_count, busy);
        end
        repeat (5) @(negedge clk);
        #1;
        compared++;
        if (busy !== 1'b0 || frame_exp !== -8'sd3) begin
            mismatched++;
            $display("FAIL idle_hold: busy=%b exp=%0d want 0 -3", busy, frame_exp);
        end
    endtask

    task automatic test_valid_toggle();
        int acc, sum;
        logic signed [DW-1:0] dc;
        logic [31:0] r;
        r = $urandom;
        next_exp = r[7:0];
        pulse_start();
        feed(1'b1, 1'b1, '0, acc, sum);
        read_frame(int'($urandom_range(0, OB - 1)), int'($urandom_range(0, 3)), -1, dc);
        compared++;
        if (dc !== DW'(sum >>> 4)) begin
            mismatched++;
            $display("FAIL dc_random: got %0d want %0d", dc, DW'(sum >>> 4));
        end
        compared++;
        if (frame_count !== 16'd2) begin
            mismatched++;
            $display("FAIL toggle_count: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_backpressure();
        int acc, sum;
        logic signed [DW-1:0] dc;
        next_exp = 8'sd7;
        pulse_start();
        feed(1'b0, 1'b1, '0, acc, sum);
        read_frame(3, 5, -1, dc);
        compared++;
        if (frame_count !== 16'd3 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL backpressure_done: count=%0d busy=%b want 3 0", frame_count, busy);
        end
    endtask

    task automatic test_continuous();
        int acc, sum;
        logic signed [DW-1:0] dc;
        logic [15:0] fc0;
        logic signed [7:0] exps [3];
        exps[0] = -8'sd2; exps[1] = 8'sd0; exps[2] = 8'sd5;
        fc0 = frame_count;
        @(negedge clk); continuous = 1'b1; #1;
        for (int f = 0; f < 3; f++) begin
            next_exp = exps[f];
            feed(1'b0, 1'b1, '0, acc, sum);
            if (f == 2) continuous = 1'b0;
            read_frame(-1, 0, -1, dc);
            compared++;
            if (frame_count !== fc0 + 16'(f + 1) || frame_exp !== exps[f] ||
                busy !== (f < 2) || sample_ready !== (f < 2)) begin
                mismatched++;
                $display("FAIL continuous frame %0d: count=%0d exp=%0d busy=%b ready=%b",
                         f, frame_count, frame_exp, busy, sample_ready);
            end
        end
    endtask

    task automatic test_start_during_run();
        int acc, sum, busy_cycles;
        logic signed [DW-1:0] dc;
        logic [15:0] fc0;
        fc0 = frame_count;
        next_exp = -8'sd1;
        pulse_start();
        feed(1'b0, 1'b1, '0, acc, sum);
        pulse_start();
        read_frame(-1, 0, -1, dc);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (busy !== 1'b0) busy_cycles++;
        end
        compared++;
        if (busy_cycles != 0 || frame_count !== fc0 + 16'd1) begin
            mismatched++;
            $display("FAIL start_ignored: busy_cycles=%0d count=%0d want 0 %0d",
                     busy_cycles, frame_count, fc0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid_read();
        int acc, sum;
        logic signed [DW-1:0] dc;
        do_reset();
        next_exp = 8'sd4;
        pulse_start();
        feed(1'b0, 1'b1, '0, acc, sum);
        read_frame(-1, 0, 5, dc);
        compared++;
        if (bin_valid !== 1'b1 || bin_index !== 3'd5 || frame_count !== 16'd0) begin
            mismatched++;
            $display("FAIL pre_abort: valid=%b idx=%0d count=%0d want 1 5 0", bin_valid, bin_index, frame_count);
        end
        @(negedge clk); reset = 1'b1; bin_ready = 1'b0;
        @(negedge clk); reset = 1'b0; #1;
        compared++;
        if (all_out !== '0) begin
            mismatched++;
            $display("FAIL abort_outputs: got %h want 0", all_out);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; sample_valid = 1'b0;
        sample_data = '0; bin_ready = 1'b0; next_exp = '0;
        test_reset();
        test_single_frame();
        test_valid_toggle();
        test_backpressure();
        test_continuous();
        test_start_during_run();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
